// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key schedule sequencer with round-key read port
// Holds the 44-word schedule and serves round keys as soon as their four words exist.

module key_expansion (
    input  logic [127:0] key_input,
    input  logic [5:0]   index,
    output logic [31:0]  key_output
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] prev;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [7:0]  rcon;

    always_comb begin
        prev = key_input[127:96];
        rot  = {prev[23:0], prev[31:24]};
        sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        case (index[5:2])
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        if (index[1:0] == 2'b00)
            key_output = key_input[31:0] ^ sub ^ {rcon, 24'h000000};
        else
            key_output = key_input[31:0] ^ prev;
    end

endmodule

module aes_key_sched_ctrl #(
    parameter int TOTAL_WORDS = 44,
    parameter int NUM_ROUNDS  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_ack,
    output logic [127:0] rk_data,
    output logic         rk_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

    state_t       state;
    state_t       state_next;
    logic [5:0]   cnt;
    logic [31:0]  w [0:TOTAL_WORDS-1];
    logic         accept;
    logic [5:0]   exp_base;
    logic [127:0] key_input;
    logic [31:0]  key_output;
    logic         round_ok;
    logic         avail;
    logic         svc;
    logic         ack_next;
    logic         err_next;
    logic [5:0]   rd_base;
    logic [5:0]   rd_last;
    logic [31:0]  rd_w3;
    logic [127:0] rd_data;

    assign accept = key_valid & key_ready;

    always_comb begin
        state_next = state;
        key_ready  = (state != EXPAND);
        busy       = (state == EXPAND);
        case (state)
            IDLE:    if (key_valid) state_next = EXPAND;
            EXPAND:  if (cnt == 6'(TOTAL_WORDS - 1)) state_next = READY;
            READY:   if (key_valid) state_next = EXPAND;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Outside EXPAND the index is parked at 4 so the window never reads out of range.
    assign exp_base  = (state == EXPAND) ? cnt : 6'd4;
    assign key_input = {w[exp_base - 6'd1], w[exp_base - 6'd2],
                        w[exp_base - 6'd3], w[exp_base - 6'd4]};

    key_expansion u_key_expansion (
        .key_input  (key_input),
        .index      (exp_base),
        .key_output (key_output)
    );

    // The word being written this edge counts as available and is bypassed into rk_data,
    // so a stalled request is acked in the cycle right after its last word is written.
    always_comb begin
        round_ok = (rk_idx <= 4'(NUM_ROUNDS));
        rd_base  = round_ok ? {rk_idx, 2'b00} : 6'd0;
        rd_last  = rd_base + 6'd3;
        avail    = (state == READY) || ((state == EXPAND) && (rd_last <= cnt));
        svc      = rk_req & ~rk_ack & ~rk_err & ~accept;
        ack_next = svc & round_ok & avail;
        err_next = svc & ~round_ok;
        rd_w3    = ((state == EXPAND) && (rd_last == cnt)) ? key_output : w[rd_last];
        rd_data  = {rd_w3, w[rd_base + 6'd2], w[rd_base + 6'd1], w[rd_base]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            done    <= 1'b0;
            rk_ack  <= 1'b0;
            rk_err  <= 1'b0;
            rk_data <= '0;
            for (int k = 0; k < TOTAL_WORDS; k++) w[k] <= '0;
        end else begin
            if (accept) begin
                w[0] <= key_in[31:0];
                w[1] <= key_in[63:32];
                w[2] <= key_in[95:64];
                w[3] <= key_in[127:96];
                cnt  <= 6'd4;
            end else if (state == EXPAND) begin
                w[cnt] <= key_output;
                cnt    <= cnt + 6'd1;
            end
            done   <= (state == EXPAND) && (cnt == 6'(TOTAL_WORDS - 1));
            rk_ack <= ack_next;
            rk_err <= err_next;
            if (ack_next) rk_data <= rd_data;
        end
    end

endmodule
